rnn_sequencer: RTL and testbench
================================

// Module: rnn_sequencer
// PURPOSE
//  Upstream driver for the rnn accelerator. Buffers a stream of character indices and looks up
//  each one's EMB_DIM-word embedding in a local table. For each character it acts as bus master
//  on the rnn register port: writes the embedding (addr 1), pulses start (addr 0), and polls
//  until done. After the last character it issues the dense step (addr 7), reads the result,
//  and presents it to the host.
// PARAMETERS
//  EMB_DIM     4    words per embedding vector
//  VOCAB       64   embedding table rows (index width IDX_W = $clog2(VOCAB))
//  DATA_W      16   embedding / result word width (signed)
//  FIFO_DEPTH  16   character FIFO entries (power of 2)
//  TIMEOUT     4096 max poll cycles per wait before error
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  char_valid   in   1       host char available
//  char_ready   out  1       FIFO not full; push when valid&ready
//  char_idx     in   IDX_W   character index
//  char_last    in   1       marks final char of sequence
//  emb_wr_en    in   1       embedding table write (ignored while busy)
//  emb_wr_row   in   IDX_W   table row
//  emb_wr_col   in   2       table column (< EMB_DIM)
//  emb_wr_data  in   DATA_W  table word
//  rnn_read     out  1       master read strobe to rnn
//  rnn_write    out  1       master write strobe to rnn
//  rnn_addr     out  32      rnn register address
//  rnn_wdata    out  32      rnn write data (-> rnn data_in)
//  rnn_rdata    in   32      rnn read data (<- rnn data_out), valid cycle after rnn_read
//  busy         out  1       FSM not in IDLE
//  result_valid out  1       one-cycle pulse, result updated
//  result       out  DATA_W  final dense output, held until next result
//  err          out  1       sticky poll timeout, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0 and FIFO flushed. Embedding table contents are retained, not cleared.
//   Reset mid-transaction aborts at once and drives no further bus cycles; the rnn is not reset.
//  FIFO: entry = {last, idx}. char_ready = !full; push blocked when full even if popping that cycle.
//   Pop occurs only in IDLE/NEXT.
//  Table: synchronous-read RAM, 1-cycle latency; write and read of same row same cycle -> old data.
//  FSM (one bus strobe max per cycle; rnn_read/rnn_write never both 1):
//   IDLE    : FIFO empty -> stay. Else pop, latch idx/last -> FETCH.
//   FETCH   : issue table read for word i=0 -> WR_EMB.
//   WR_EMB  : rnn_write=1, addr=1, wdata={16'(i), E[idx][i]}; i=0..EMB_DIM-1 on consecutive
//             cycles (next word prefetched) -> START.
//   START   : rnn_write=1, addr=0, wdata=0 for one cycle -> POLL.
//   POLL    : rnn_read=1, addr=0 every other cycle; sample rnn_rdata[0] the following cycle.
//             rdata[0]=1 means done. done & !last -> NEXT; done & last -> DENSE.
//   NEXT    : FIFO non-empty -> pop -> FETCH; else wait here (sequence still open).
//   DENSE   : rnn_write=1, addr=7, wdata=0 one cycle -> POLL2 (same polling as POLL) -> RD_RES.
//   RD_RES  : rnn_read=1, addr=8; next cycle result <= rnn_rdata[DATA_W-1:0], result_valid=1 -> IDLE.
//   ERR     : entered when a poll wait exceeds TIMEOUT cycles; err=1, no bus activity; exit only on rst.
//  Poll counter resets on entering each POLL/POLL2. Idle bus: rnn_addr/rnn_wdata hold 0.
//  Latency per char = 1 + EMB_DIM + 1 + poll time. busy=1 in every state except IDLE.
// TESTING
//  T1 reset: rst high 3 cycles mid-WR_EMB -> next cycle all outputs 0, no strobes, char_ready=1.
//  T2 single char: E[5]={1,-2,3,-4}, push idx5 last=1 -> writes addr1 data 0x00000001,
//     0x0001FFFE, 0x00020003, 0x0003FFFC on 4 consecutive cycles; then addr0; polls; addr7; addr8.
//     Model returns 17595 -> result=17595, result_valid pulse exactly once.
//  T3 sequence: push idx 0,1,2 (last on 2) with model done after 10 cycles -> exactly 3 starts,
//     1 dense, order preserved.
//  T4 FIFO full: push 16 with FSM stalled in POLL -> char_ready=0; 17th push ignored;
//     entry count stays 16.
//  T5 timeout: model never asserts done, TIMEOUT=64 -> err=1 within 65 cycles of START; bus idle;
//     rst clears err.
//  T6 table write while busy: emb_wr_en during POLL -> table unchanged (verify on next sequence).

Source files
------------

// File: rtl/rnn_sequencer.sv
// Host-side sequencer for the rnn accelerator: buffers character indices, looks up their
// embeddings and drives the rnn register port through load/start/poll/dense/read-back.
module rnn_sequencer #(
    parameter int EMB_DIM    = 4,
    parameter int VOCAB      = 64,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 4096,
    localparam int IDX_W     = $clog2(VOCAB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [IDX_W-1:0]  char_idx,
    input  logic              char_last,
    input  logic              emb_wr_en,
    input  logic [IDX_W-1:0]  emb_wr_row,
    input  logic [1:0]        emb_wr_col,
    input  logic [DATA_W-1:0] emb_wr_data,
    output logic              rnn_read,
    output logic              rnn_write,
    output logic [31:0]       rnn_addr,
    output logic [31:0]       rnn_wdata,
    input  logic [31:0]       rnn_rdata,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int COL_W = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR_EMB, S_START, S_POLL, S_NEXT,
        S_DENSE, S_POLL2, S_RD_RES, S_RES_CAP, S_ERR
    } state_t;

    state_t state, state_next;

    // Character FIFO: entry = {last, idx}; pointers carry one wrap bit.
    logic [IDX_W:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr, rd_ptr;
    logic [IDX_W:0]  head;
    logic            full, empty, push, pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign char_ready = !full;
    assign push       = char_valid && !full && !rst;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers/FSM, and the
    // embedding table must survive rst by design.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {char_last, char_idx};
    end

    logic signed [DATA_W-1:0] emb_mem [VOCAB][EMB_DIM];
    logic signed [DATA_W-1:0] emb_q;
    logic [COL_W-1:0]         rd_col;
    logic [IDX_W-1:0]         cur_idx;
    logic                     cur_last;
    logic [COL_W-1:0]         word_i;
    logic [CNT_W-1:0]         poll_cnt;
    logic                     poll_phase;

    // Host table writes are only honoured while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (emb_wr_en && state == S_IDLE && 32'(emb_wr_col) < EMB_DIM)
            emb_mem[emb_wr_row][emb_wr_col[COL_W-1:0]] <= emb_wr_data;
        emb_q <= emb_mem[cur_idx][rd_col];
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rd_col     = '0;
        rnn_read   = 1'b0;
        rnn_write  = 1'b0;
        rnn_addr   = '0;
        rnn_wdata  = '0;
        case (state)
            S_IDLE, S_NEXT: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_WR_EMB;
            S_WR_EMB: begin
                rnn_write = 1'b1;
                rnn_addr  = 32'd1;
                rnn_wdata = {16'(word_i), 16'(emb_q)};
                if (word_i == COL_W'(EMB_DIM - 1)) state_next = S_START;
                else                               rd_col     = word_i + COL_W'(1);
            end
            S_START: begin
                rnn_write  = 1'b1;
                state_next = S_POLL;
            end
            S_POLL, S_POLL2: begin
                // Even phase issues the read, odd phase consumes the returned status.
                if (poll_phase && rnn_rdata[0])
                    state_next = (state == S_POLL2) ? S_RD_RES : (cur_last ? S_DENSE : S_NEXT);
                else if (poll_cnt == CNT_W'(TIMEOUT - 1))
                    state_next = S_ERR;
                else if (!poll_phase)
                    rnn_read = 1'b1;
            end
            S_DENSE: begin
                rnn_write  = 1'b1;
                rnn_addr   = 32'd7;
                state_next = S_POLL2;
            end
            S_RD_RES: begin
                rnn_read   = 1'b1;
                rnn_addr   = 32'd8;
                state_next = S_RES_CAP;
            end
            S_RES_CAP: state_next = S_IDLE;
            S_ERR:     state_next = S_ERR;
            default:   state_next = S_IDLE;
        endcase
        if (rst) begin
            pop       = 1'b0;
            rnn_read  = 1'b0;
            rnn_write = 1'b0;
            rnn_addr  = '0;
            rnn_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_idx      <= '0;
            cur_last     <= 1'b0;
            word_i       <= '0;
            poll_cnt     <= '0;
            poll_phase   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= 1'b0;
            if (pop) {cur_last, cur_idx} <= head;
            word_i <= (state == S_WR_EMB) ? word_i + COL_W'(1) : '0;
            if (state == S_POLL || state == S_POLL2) begin
                poll_cnt   <= poll_cnt + CNT_W'(1);
                poll_phase <= !poll_phase;
            end else begin
                poll_cnt   <= '0;
                poll_phase <= 1'b0;
            end
            if (state == S_RES_CAP) begin
                result       <= rnn_rdata[DATA_W-1:0];
                result_valid <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign err  = (state == S_ERR);

    logic rdata_unused;
    assign rdata_unused = ^rnn_rdata[31:DATA_W];

endmodule

// File: tb/tb_rnn_sequencer.sv
// Bench for rnn_sequencer: a behavioural rnn register model answers the bus, expected bus writes
// and results are queued by the stimulus and consumed by an independent monitor.
module tb_rnn_sequencer;

    localparam int IDX_W  = 6;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic [IDX_W-1:0]  char_idx = '0;
    logic              char_last = 1'b0;
    logic              emb_wr_en = 1'b0;
    logic [IDX_W-1:0]  emb_wr_row = '0;
    logic [1:0]        emb_wr_col = '0;
    logic [DATA_W-1:0] emb_wr_data = '0;
    logic              rnn_read, rnn_write;
    logic [31:0]       rnn_addr, rnn_wdata;
    logic [31:0]       rnn_rdata = '0;
    logic              busy, result_valid, err;
    logic [DATA_W-1:0] result;

    rnn_sequencer #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .char_valid(char_valid), .char_ready(char_ready), .char_idx(char_idx), .char_last(char_last),
        .emb_wr_en(emb_wr_en), .emb_wr_row(emb_wr_row), .emb_wr_col(emb_wr_col), .emb_wr_data(emb_wr_data),
        .rnn_read(rnn_read), .rnn_write(rnn_write), .rnn_addr(rnn_addr), .rnn_wdata(rnn_wdata),
        .rnn_rdata(rnn_rdata), .busy(busy), .result_valid(result_valid), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // rnn register model: writes to addr 0 / 7 start a run that completes after model_delay cycles.
    int          model_delay  = 10;
    bit          never_done   = 1'b0;
    logic [15:0] model_result = '0;
    int          mcnt  = 0;
    logic        mdone = 1'b0;

    always @(posedge clk) begin
        if (rnn_write && (rnn_addr == 32'd0 || rnn_addr == 32'd7)) begin
            mdone <= 1'b0;
            mcnt  <= never_done ? 0 : model_delay;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mdone <= 1'b1;
        end
        if (rnn_read)
            rnn_rdata <= (rnn_addr == 32'd8) ? {16'hABCD, model_result} : {31'b0, mdone};
        else
            rnn_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct {
        bit          is_res;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit [15:0] emb_model [64][4];

    int n_vec = 0, n_err = 0;
    int n_start = 0, n_dense = 0, n_res = 0;
    int start_cyc = 0;
    bit sb_en = 1'b0;
    bit prev_emb_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_en) begin
            if (rnn_write) begin
                check("single_strobe", 32'(rnn_read), 32'd0);
                if (rnn_addr == 32'd0) begin
                    n_start++;
                    start_cyc = cyc;
                end
                if (rnn_addr == 32'd7) n_dense++;
                if (rnn_addr == 32'd1 && rnn_wdata[31:16] != 16'd0)
                    check("emb_consecutive", 32'(prev_emb_wr), 32'd1);
                if (exp_q.size() == 0) begin
                    check("write_with_nothing_expected", rnn_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_write", 32'd0, 32'(e.is_res));
                    check("wr_addr", rnn_addr, e.addr);
                    check("wr_data", rnn_wdata, e.data);
                end
            end
            if (result_valid) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    check("result_with_nothing_expected", {16'd0, result}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_result", 32'd1, 32'(e.is_res));
                    check("result", {16'd0, result}, e.data);
                end
            end
        end
        prev_emb_wr = rnn_write && (rnn_addr == 32'd1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic tbl_write(input int row, input int col, input logic [15:0] data, input bit upd);
        emb_wr_en   = 1'b1;
        emb_wr_row  = 6'(row);
        emb_wr_col  = 2'(col);
        emb_wr_data = data;
        tick();
        emb_wr_en = 1'b0;
        if (upd) emb_model[row][col] = data;
    endtask

    task automatic drive_char(input int idx, input bit last);
        char_valid = 1'b1;
        char_idx   = 6'(idx);
        char_last  = last;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic exp_char(input int idx, input bit last, input bit with_tail);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{is_res: 1'b0, addr: 32'd1, data: {16'(i), emb_model[idx][i]}});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd0, data: 32'd0});
        if (last && with_tail) begin
            exp_q.push_back('{is_res: 1'b0, addr: 32'd7, data: 32'd0});
            exp_q.push_back('{is_res: 1'b1, addr: 32'd0, data: {16'd0, model_result}});
        end
    endtask

    task automatic push_char(input int idx, input bit last);
        exp_char(idx, last, 1'b1);
        drive_char(idx, last);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < max_cyc) begin
            tick();
            k++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_read(input string name);
        int k = 0;
        while (!rnn_read && k < 100) begin
            tick();
            k++;
        end
        check(name, 32'(rnn_read), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rnn_read"},     32'(rnn_read),     32'd0);
        check({tag, "_rnn_write"},    32'(rnn_write),    32'd0);
        check({tag, "_rnn_addr"},     rnn_addr,          32'd0);
        check({tag, "_rnn_wdata"},    rnn_wdata,         32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_err"},          32'(err),          32'd0);
        check({tag, "_char_ready"},   32'(char_ready),   32'd1);
    endtask

    initial begin
        int s0, d0, r0, k, act, err_cyc;
        bit found;

        tick(3);
        rst = 1'b0;
        check_quiet("por");
        check("por_result", {16'd0, result}, 32'd0);

        tbl_write(5, 0, 16'h0001, 1'b1); tbl_write(5, 1, 16'hFFFE, 1'b1);
        tbl_write(5, 2, 16'h0003, 1'b1); tbl_write(5, 3, 16'hFFFC, 1'b1);
        tbl_write(0, 0, 16'd10, 1'b1);   tbl_write(0, 1, 16'd20, 1'b1);
        tbl_write(0, 2, 16'd30, 1'b1);   tbl_write(0, 3, 16'd40, 1'b1);
        tbl_write(1, 0, 16'hFFFF, 1'b1); tbl_write(1, 1, 16'hFFFF, 1'b1);
        tbl_write(1, 2, 16'h0000, 1'b1); tbl_write(1, 3, 16'h7FFF, 1'b1);
        tbl_write(2, 0, 16'd100, 1'b1);  tbl_write(2, 1, 16'hFF9C, 1'b1);
        tbl_write(2, 2, 16'h1234, 1'b1); tbl_write(2, 3, 16'h8000, 1'b1);

        // T1: abort mid-embedding-load
        drive_char(5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rnn_write && rnn_addr == 32'd1) found = 1'b1;
            else tick();
        end
        check("t1_reached_wr_emb", 32'(found), 32'd1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_quiet("t1");
        act = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rnn_read || rnn_write || busy) act++;
        end
        check("t1_no_activity_after_rst", act, 32'd0);

        // T2: single character, hand-computed bus words
        sb_en = 1'b1;
        model_delay  = 6;
        model_result = 16'd17595;
        s0 = n_start; d0 = n_dense; r0 = n_res;
        exp_q.push_back('{is_res: 1'b0, addr: 32'd1, data: 32'h0000_0001});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd1, data: 32'h0001_FFFE});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd1, data: 32'h0002_0003});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd1, data: 32'h0003_FFFC});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd0, data: 32'd0});
        exp_q.push_back('{is_res: 1'b0, addr: 32'd7, data: 32'd0});
        exp_q.push_back('{is_res: 1'b1, addr: 32'd0, data: 32'd17595});
        drive_char(5, 1'b1);
        wait_done("t2", 300);
        tick(5);
        check("t2_starts", n_start - s0, 32'd1);
        check("t2_dense",  n_dense - d0, 32'd1);
        check("t2_result_pulses", n_res - r0, 32'd1);
        check("t2_result_held", {16'd0, result}, 32'd17595);

        // T3: three-character sequence
        model_delay  = 10;
        model_result = 16'hFB2E;
        s0 = n_start; d0 = n_dense; r0 = n_res;
        push_char(0, 1'b0);
        push_char(1, 1'b0);
        push_char(2, 1'b1);
        wait_done("t3", 600);
        check("t3_starts", n_start - s0, 32'd3);
        check("t3_dense",  n_dense - d0, 32'd1);
        check("t3_result_pulses", n_res - r0, 32'd1);

        // T6: table writes while busy are dropped
        model_delay  = 8;
        model_result = 16'h0042;
        push_char(5, 1'b1);
        wait_read("t6_in_poll");
        tbl_write(5, 0, 16'h5555, 1'b0);
        tbl_write(5, 3, 16'h7777, 1'b0);
        wait_done("t6a", 300);
        model_result = 16'h0043;
        push_char(5, 1'b1);
        wait_done("t6b", 300);

        // T4: fill the FIFO while the FSM is stalled in POLL
        model_delay  = 40;
        model_result = 16'h0100;
        s0 = n_start; d0 = n_dense;
        push_char(1, 1'b0);
        wait_read("t4_in_poll");
        for (int i = 0; i < 16; i++) begin
            k = (i % 4 == 3) ? 5 : i % 4;
            push_char(k, i == 15);
        end
        check("t4_ready_low_when_full", 32'(char_ready), 32'd0);
        drive_char(5, 1'b1);
        check("t4_ready_low_after_17th", 32'(char_ready), 32'd0);
        wait_done("t4", 4000);
        check("t4_starts", n_start - s0, 32'd17);
        check("t4_dense",  n_dense - d0, 32'd1);

        // T5: poll timeout
        never_done = 1'b1;
        exp_char(2, 1'b1, 1'b0);
        drive_char(2, 1'b1);
        k = 0;
        while (!err && k < 300) begin
            tick();
            k++;
        end
        err_cyc = cyc;
        check("t5_err_set", 32'(err), 32'd1);
        check("t5_err_not_early", 32'((err_cyc - start_cyc) >= 64), 32'd1);
        check("t5_err_within_65", 32'((err_cyc - start_cyc) <= 65), 32'd1);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        act = 0;
        for (int i = 0; i < 10; i++) begin
            if (rnn_read || rnn_write || rnn_addr != 32'd0 || rnn_wdata != 32'd0) act++;
            tick();
        end
        check("t5_bus_idle", act, 32'd0);
        check("t5_err_sticky", 32'(err), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        never_done = 1'b0;
        check("t5_err_cleared", 32'(err), 32'd0);
        check("t5_idle_after_rst", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
